// File: rtl/seqmult_datapath.sv
// Sequential shift-add multiplier datapath: operand capture on enter presses, WIDTH-cycle multiply, hex display.
// Optional build macro SEQMULT_SIGNED_EN selects two's-complement operands (final iteration subtracts).
module seqmult_datapath #(
   parameter int WIDTH   = 8,
   parameter int NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enter,
   input  logic [WIDTH-1:0]       inputdata,
   input  logic                   loaddata,
   output logic                   inputdata_ready,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH-1:0]     product,
   output logic [7*NDIGITS-1:0]   disp
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = 4 * NDIGITS;

   typedef enum logic [1:0] {LOAD_A, LOAD_B, MULT, SHOW} state_t;

   state_t          state_q, state_d;
   logic            e_q1, e_q2;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   product_q, product_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            enter_pulse;
   logic [PW-1:0]   acc_next;
   logic [DW-1:0]   disp_src;

   assign enter_pulse     = e_q1 & ~e_q2;
   assign inputdata_ready = ((state_q == LOAD_A) || (state_q == LOAD_B)) && loaddata;
   assign busy            = (state_q == MULT);
   assign done            = done_q;
   assign product         = product_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD_A;
         e_q1      <= 1'b0;
         e_q2      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         e_q1      <= enter;
         e_q2      <= e_q1;
         a_q       <= a_d;
         b_q       <= b_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      acc_next  = acc_q;

      case (state_q)
         LOAD_A: begin
            if (enter_pulse && loaddata) begin
               a_d     = inputdata;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (enter_pulse && loaddata) begin
               b_d       = inputdata;
`ifdef SEQMULT_SIGNED_EN
               mcand_d   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
`else
               mcand_d   = {{WIDTH{1'b0}}, a_q};
`endif
               acc_d     = '0;
               product_d = '0;
               cnt_d     = CW'(WIDTH);
               state_d   = MULT;
            end
         end
         MULT: begin
            // b_q shifts right so its LSB is always the current multiplier bit.
`ifdef SEQMULT_SIGNED_EN
            if (b_q[0] && (cnt_q == CW'(1)))
               acc_next = acc_q - mcand_q;
            else if (b_q[0])
               acc_next = acc_q + mcand_q;
`else
            if (b_q[0])
               acc_next = acc_q + mcand_q;
`endif
            acc_d   = acc_next;
            b_d     = b_q >> 1;
            mcand_d = mcand_q << 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               product_d = acc_next;
               done_d    = 1'b1;
               state_d   = SHOW;
            end
         end
         SHOW: begin
            if (enter_pulse)
               state_d = LOAD_A;
         end
         default: state_d = LOAD_A;
      endcase
   end

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      disp_src = DW'(inputdata);
      case (state_q)
         MULT:    disp_src = DW'(a_q);
         SHOW:    disp_src = DW'(product_q);
         default: disp_src = DW'(inputdata);
      endcase
   end

   always_comb begin
      disp = '0;
      for (int i = 0; i < NDIGITS; i++)
         disp[7*i +: 7] = seg7(disp_src[4*i +: 4]);
   end

endmodule

// File: tb/tb_seqmult_datapath.sv
// Directed self-checking bench for seqmult_datapath (WIDTH=8, NDIGITS=4).
// Expected products track the SEQMULT_SIGNED_EN build macro.
module tb_seqmult_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enter = 1'b0;
   logic [7:0]  inputdata = '0;
   logic        loaddata = 1'b0;
   logic        inputdata_ready;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [27:0] disp;

   int errors = 0;
   int checks = 0;

   seqmult_datapath #(.WIDTH(8), .NDIGITS(4)) dut (
      .clk(clk),
      .reset(reset),
      .enter(enter),
      .inputdata(inputdata),
      .loaddata(loaddata),
      .inputdata_ready(inputdata_ready),
      .busy(busy),
      .done(done),
      .product(product),
      .disp(disp)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   function automatic logic [27:0] disp4(input logic [15:0] v);
      disp4 = {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the capture edge just behind us, with enter low for the next press
   task automatic press_enter(input logic [7:0] data);
      inputdata = data;
      enter = 1'b0;
      tick();
      enter = 1'b1;
      tick();
      tick();
      enter = 1'b0;
   endtask

   task automatic run_from_b(input logic [7:0] b, output int edges, output int busy_cnt,
                             output logic [27:0] disp_mult, output logic [15:0] prod);
      press_enter(b);
      disp_mult = disp;
      edges = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && edges < 20) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         edges++;
      end
      prod = product;
   endtask

   task automatic run_mult(input logic [7:0] a, input logic [7:0] b, output int edges,
                           output int busy_cnt, output logic [27:0] disp_mult, output logic [15:0] prod);
      press_enter(a);
      run_from_b(b, edges, busy_cnt, disp_mult, prod);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      loaddata = 1'b1;
      inputdata = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", inputdata_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
      checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product got=%h exp=0000", product); end
      checks++; if (disp !== {4{7'b1000000}}) begin errors++; $display("[TB] FAIL reset_disp got=%h exp=%h", disp, {4{7'b1000000}}); end
      loaddata = 1'b0;
      inputdata = 8'hA5;
      #1;
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_noload got=%b exp=0", inputdata_ready); end
      checks++; if (disp !== {7'h40, 7'h40, 7'h08, 7'h12}) begin errors++; $display("[TB] FAIL live_disp got=%h exp=%h", disp, {7'h40, 7'h40, 7'h08, 7'h12}); end
      loaddata = 1'b1;
   endtask

   task automatic test_basic();
      int edges, busy_cnt;
      logic [27:0] dm;
      logic [15:0] prod;
      run_mult(8'h0C, 8'h0D, edges, busy_cnt, dm, prod);
      checks++; if (dm !== {7'h40, 7'h40, 7'h40, 7'h46}) begin errors++; $display("[TB] FAIL basic_disp_mult got=%h exp=%h", dm, {7'h40, 7'h40, 7'h40, 7'h46}); end
      checks++; if (edges != 8) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=8", edges); end
      checks++; if (busy_cnt != 8) begin errors++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=8", busy_cnt); end
      checks++; if (prod !== 16'h009C) begin errors++; $display("[TB] FAIL basic_product got=%h exp=009C", prod); end
      checks++; if (disp !== {7'h40, 7'h40, 7'h10, 7'h46}) begin errors++; $display("[TB] FAIL basic_disp got=%h exp=%h", disp, {7'h40, 7'h40, 7'h10, 7'h46}); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width got=%b exp=0", done); end
      checks++; if (product !== 16'h009C) begin errors++; $display("[TB] FAIL basic_product_hold got=%h exp=009C", product); end
      press_enter(8'h00);
      checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_back_to_load got=%b exp=1", inputdata_ready); end
   endtask

   task automatic test_max_hold();
      int edges, busy_cnt, rises;
      logic [27:0] dm;
      logic [15:0] prod;
      logic in_load, prev_load;
      run_mult(8'hFF, 8'hFF, edges, busy_cnt, dm, prod);
`ifdef SEQMULT_SIGNED_EN
      checks++; if (prod !== 16'h0001) begin errors++; $display("[TB] FAIL max_product got=%h exp=0001", prod); end
`else
      checks++; if (prod !== 16'hFE01) begin errors++; $display("[TB] FAIL max_product got=%h exp=FE01", prod); end
      checks++; if (disp !== {7'h0E, 7'h06, 7'h40, 7'h79}) begin errors++; $display("[TB] FAIL max_disp got=%h exp=%h", disp, {7'h0E, 7'h06, 7'h40, 7'h79}); end
`endif
      checks++; if (edges != 8) begin errors++; $display("[TB] FAIL max_latency got=%0d exp=8", edges); end
      inputdata = 8'h00;
      tick();
      enter = 1'b1;
      rises = 0;
      prev_load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         in_load = (disp === disp4(16'h0000));
         if (in_load && !prev_load) rises++;
         prev_load = in_load;
      end
      enter = 1'b0;
      checks++; if (rises != 1) begin errors++; $display("[TB] FAIL hold_transitions got=%0d exp=1", rises); end
      press_enter(8'h03);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_still_load_a got=%b exp=0", busy); end
      run_from_b(8'h05, edges, busy_cnt, dm, prod);
      checks++; if (prod !== 16'h000F) begin errors++; $display("[TB] FAIL hold_product got=%h exp=000F", prod); end
      press_enter(8'h00);
   endtask

   task automatic test_ignored();
      int edges;
      logic saw_busy_drop;
      loaddata = 1'b0;
      press_enter(8'h77);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_load_a_busy got=%b exp=0", busy); end
      loaddata = 1'b1;
      press_enter(8'h12);
      loaddata = 1'b0;
      press_enter(8'h99);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_load_b_busy got=%b exp=0", busy); end
      loaddata = 1'b1;
      press_enter(8'h34);
      edges = 0;
      saw_busy_drop = 1'b0;
      while (done !== 1'b1 && edges < 20) begin
         if (edges == 1) enter = 1'b1;
         if (edges == 2) loaddata = 1'b0;
         if (edges == 3 && disp !== disp4(16'h0012)) begin
            errors++;
            $display("[TB] FAIL ign_disp_mult got=%h exp=%h", disp, disp4(16'h0012));
         end
         if (edges == 4) enter = 1'b0;
         if (edges == 5) enter = 1'b1;
         if (edges == 7) enter = 1'b0;
         if (busy !== 1'b1) saw_busy_drop = 1'b1;
         tick();
         edges++;
      end
      checks++;
      checks++; if (edges != 8) begin errors++; $display("[TB] FAIL ign_latency got=%0d exp=8", edges); end
      checks++; if (saw_busy_drop !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy_gap got=%b exp=0", saw_busy_drop); end
      checks++; if (product !== 16'h03A8) begin errors++; $display("[TB] FAIL ign_product got=%h exp=03A8", product); end
      tick();
      tick();
      checks++; if (disp !== disp4(16'h03A8)) begin errors++; $display("[TB] FAIL ign_show_stays got=%h exp=%h", disp, disp4(16'h03A8)); end
      loaddata = 1'b1;
      press_enter(8'h00);
   endtask

   task automatic test_reset_mid();
      int seen_done;
      press_enter(8'h12);
      press_enter(8'h34);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
      checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_product got=%h exp=0000", product); end
      checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready got=%b exp=1", inputdata_ready); end
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) seen_done++;
         tick();
      end
      checks++; if (seen_done != 0) begin errors++; $display("[TB] FAIL rst_mid_done got=%0d exp=0", seen_done); end
   endtask

   task automatic test_sign_vectors();
      int edges, busy_cnt;
      logic [27:0] dm;
      logic [15:0] prod;
      logic [15:0] exp_fd;
`ifdef SEQMULT_SIGNED_EN
      exp_fd = 16'hFFF1;
`else
      exp_fd = 16'h04F1;
`endif
      run_mult(8'hFD, 8'h05, edges, busy_cnt, dm, prod);
      checks++; if (prod !== exp_fd) begin errors++; $display("[TB] FAIL fd_x_05 got=%h exp=%h", prod, exp_fd); end
      checks++; if (busy_cnt != 8) begin errors++; $display("[TB] FAIL fd_busy got=%0d exp=8", busy_cnt); end
      press_enter(8'h00);
      run_mult(8'h80, 8'h80, edges, busy_cnt, dm, prod);
      checks++; if (prod !== 16'h4000) begin errors++; $display("[TB] FAIL 80_x_80 got=%h exp=4000", prod); end
      checks++; if (edges != 8) begin errors++; $display("[TB] FAIL 80_latency got=%0d exp=8", edges); end
      press_enter(8'h00);
   endtask

   // Scenario sequence, then the single summary line
   initial begin
      test_reset();
      test_basic();
      test_max_hold();
      test_ignored();
      test_reset_mid();
      test_sign_vectors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seqmult_datapath.md
# seqmult_datapath

Parametrised sequential multiplier datapath for the board-level multiplier design. It collects two WIDTH-bit operands from the switches on debounced `enter` presses and multiplies them with a WIDTH-cycle shift-add engine. The result drives NDIGITS active-low hex seven-segment digits. It generalises the fixed 8-bit, four-digit datapath unit in width, digit count and signedness, and adds explicit busy/done status.

## Interface
- `WIDTH`, default 8: operand width; legal range 2..16.
- `NDIGITS`, default 4: number of hex display digits; legal range 1..8.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high; clears all state.
- `enter` input, 1 bit: level from an already-debounced pushbutton.
- `inputdata` input, WIDTH bits: operand value from the switches.
- `loaddata` input, 1 bit: operand-load enable from the control unit.
- `inputdata_ready` output, 1 bit: high while the block will accept an operand.
- `busy` output, 1 bit: high during multiplication.
- `done` output, 1 bit: one-cycle pulse when the product becomes valid.
- `product` output, 2*WIDTH bits: registered result.
- `disp` output, 7*NDIGITS bits: digit i occupies bits [7i+6:7i]. Segment order is g..a, MSB first, active-low.

## Operation
- Enter edge detection:
  - `e_q1 <= enter`, `e_q2 <= e_q1`.
  - `enter_pulse = e_q1 & ~e_q2`.
  - A held button yields exactly one pulse.
- FSM states are LOAD_A, LOAD_B, MULT and SHOW. The reset state is LOAD_A.
- LOAD_A: `enter_pulse & loaddata` latches `inputdata` into A and moves to LOAD_B.
- LOAD_B: `enter_pulse & loaddata` latches `inputdata` into B, clears the accumulator and `product`, loads the cycle counter with WIDTH, and moves to MULT.
- MULT: one iteration per cycle:
  - If multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplier right and the multiplicand left.
  - Decrement the counter.
  - When the counter reaches 0, write the accumulator to `product`, pulse `done`, and move to SHOW.
- SHOW: `enter_pulse` (independent of `loaddata`) moves to LOAD_A. `product` holds its value until the next MULT entry.
- `inputdata_ready` = (state is LOAD_A or LOAD_B) & `loaddata`. It is combinational from the state register and the input.
- `busy` = (state is MULT).
- Display value, zero-extended or truncated to 4*NDIGITS bits:
  - LOAD_A and LOAD_B: live `inputdata`.
  - MULT: A.
  - SHOW: `product`.
- Each nibble is decoded to standard hex glyphs 0–F, active-low.
- Arithmetic: unsigned by default. The accumulator is 2*WIDTH bits and cannot overflow.
- Boundaries:
  - `enter_pulse` in MULT is ignored.
  - `enter_pulse` with `loaddata`=0 in LOAD_A or LOAD_B is ignored, and the state is unchanged.
  - `loaddata` dropping mid-MULT has no effect.
  - `reset` in any state, including mid-MULT, returns to LOAD_A on the next edge. It clears A, B, the accumulator, `product`, `done` and the edge-detect flops.
  - `reset` takes priority over `enter_pulse` in the same cycle.

## Timing
- Reset values:
  - `product`=0, `done`=0, `busy`=0.
  - `inputdata_ready` = `loaddata` (state LOAD_A).
  - `disp` shows `inputdata`. With `inputdata`=0, every digit is 7'b1000000.
- Enter latency: `enter` rises before edge k; `enter_pulse` is high in cycle k..k+1; the capture or transition happens at edge k+1.
- MULT occupancy: exactly WIDTH cycles. `busy` is high for WIDTH cycles starting the cycle after B capture.
- `done` is high for exactly one cycle, coincident with the first SHOW cycle. `product` is valid in that cycle.
- End-to-end: from the B-capturing edge to `done` high is WIDTH edges.
- `disp` is combinational from registered state plus `inputdata`. It has no added latency.

## Configuration
- `SEQMULT_SIGNED_EN` defined:
  - Operands are two's complement.
  - MULT adds WIDTH-1 iterations as normal; the final iteration subtracts the multiplicand when B's MSB is 1.
  - The multiplicand is sign-extended to 2*WIDTH bits.
  - `product` is a two's-complement 2*WIDTH-bit result.
  - `disp` shows raw hex bits, with no sign glyph.
- Not defined: unsigned multiply as above. Cycle count and interface are identical in both builds.

## Test plan
- Reset, then hold `loaddata`=1 and `inputdata`=8'h00 -> `inputdata_ready`=1, `busy`=0, `product`=0, all four digits 7'b1000000.
- Unsigned, WIDTH=8: A=8'h0C, B=8'h0D via two `enter` presses -> `busy` high for 8 cycles, `done` one cycle, `product`=16'h009C, display "009C".
- Unsigned 8'hFF×8'hFF -> `product`=16'hFE01. Then hold `enter` high for 20 cycles -> exactly one transition to LOAD_A.
- `enter` pulses during MULT and with `loaddata`=0 in LOAD_A -> ignored; state and operands unchanged, and `done` still arrives 8 cycles after B capture.
- Assert `reset` at MULT cycle 3 of 8'h12×8'h34 -> LOAD_A next cycle, `product`=0, `done` never pulses.
- `SEQMULT_SIGNED_EN`, WIDTH=8:
  - 8'hFD×8'h05 -> `product`=16'hFFF1.
  - 8'h80×8'h80 -> 16'h4000.
  - Both complete in 8 MULT cycles.
